load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access size codes,
// default memory depth and the alignment rule used to decide faults.
package lsu_pkg;

  // Default number of 32-bit words in the attached data memory.
  localparam int LSU_DEPTH = 8;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_MRG  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

  // Access size codes carried on req_size.
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // True when the size code is illegal or the byte offset is misaligned for it.
  function automatic logic alignFault(input logic [1:0] size, input logic [1:0] lowAddr);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lowAddr[0];
      SZ_WORD: return |lowAddr;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational big-endian lane logic: pulls a byte/half/word out of a
// memory word with sign or zero extension, and merges right-aligned store data
// into a memory word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  output logic [31:0] extractData,
  output logic [31:0] mergeData
);

  // Byte offset 0 is the most significant byte; half offset 0 is bits 31:16.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Replaces only the addressed lane; the rest of the read word is preserved.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] m;
    m = w;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    m[31:24] = wd[7:0];
          2'd1:    m[23:16] = wd[7:0];
          2'd2:    m[15:8]  = wd[7:0];
          default: m[7:0]   = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) m[15:0]  = wd[15:0];
        else        m[31:16] = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  // Both results are always computed; the FSM decides which one to register.
  always_comb begin
    extractData = extract(word, offset, size, isUnsigned);
    mergeData   = merge(word, wdata, offset, size);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end for the MIPS data memory. Accepts one load/store at a
// time, faults misaligned/out-of-range/illegal-size requests, turns sub-word
// stores into read-modify-write, and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writeIn,
  output logic        mem_writePin,
  output logic        mem_readPin,
  input  logic [31:0] mem_readOut
);

  logic [2:0]  state;
  logic [2:0]  nextState;

  // Request fields captured at accept; inputs are ignored after that.
  logic        reqStore;
  logic        reqUnsigned;
  logic [1:0]  reqSize;
  logic [1:0]  reqOffset;
  logic [31:0] reqWdata;

  logic        accept;
  logic        reqFault;
  logic        reqWordStore;
  logic [31:0] wordIndex;
  logic [31:0] extractData;
  logic [31:0] mergeData;

  assign wordIndex    = {2'b00, req_addr[31:2]};
  assign reqFault     = alignFault(req_size, req_addr[1:0]) || (wordIndex >= $unsigned(DEPTH));
  assign reqWordStore = req_store && (req_size == SZ_WORD);
  assign accept       = req_valid && (state == ST_IDLE);

  // Handshake and strobes decode from state only; reset gates them so a WR
  // cycle that coincides with reset never reaches the memory.
  assign req_ready    = reset || (state == ST_IDLE);
  assign resp_valid   = !reset && (state == ST_RSP);
  assign mem_readPin  = !reset && (state == ST_RD);
  assign mem_writePin = !reset && (state == ST_WR);

  lsu_align uAlign (
    .word        (mem_readOut),
    .wdata       (reqWdata),
    .offset      (reqOffset),
    .size        (reqSize),
    .isUnsigned  (reqUnsigned),
    .extractData (extractData),
    .mergeData   (mergeData)
  );

  // Next-state selection for the IDLE -> (RD -> MRG) -> (WR) -> RSP sequence.
  always_comb begin
    // NOTE: assigning a default first means every path drives nextState, so no latch is inferred.
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (reqFault)          nextState = ST_RSP;
          else if (reqWordStore) nextState = ST_WR;
          else                   nextState = ST_RD;
        end
      end
      ST_RD:   nextState = ST_MRG;
      ST_MRG:  nextState = reqStore ? ST_WR : ST_RSP;
      ST_WR:   nextState = ST_RSP;
      ST_RSP:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // State, captured request and registered memory/response datapath.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, matching the hardware.
    if (reset) begin
      state       <= ST_IDLE;
      reqStore    <= 1'b0;
      reqUnsigned <= 1'b0;
      reqSize     <= SZ_BYTE;
      reqOffset   <= 2'd0;
      reqWdata    <= 32'h0;
      mem_adr     <= 32'h0;
      mem_writeIn <= 32'h0;
      resp_rdata  <= 32'h0;
      resp_fault  <= 1'b0;
    end else begin
      state <= nextState;

      if (accept) begin
        reqStore    <= req_store;
        reqUnsigned <= req_unsigned;
        reqSize     <= req_size;
        reqOffset   <= req_addr[1:0];
        reqWdata    <= req_wdata;
        mem_adr     <= wordIndex;
        // A word store skips the read, so its write word is ready at accept.
        if (reqWordStore && !reqFault) mem_writeIn <= req_wdata;
        // Faults go straight to RSP; response fields change only when entering RSP.
        if (reqFault) begin
          resp_rdata <= 32'h0;
          resp_fault <= 1'b1;
        end
      end

      if (state == ST_MRG) begin
        if (reqStore) begin
          mem_writeIn <= mergeData;
        end else begin
          resp_rdata <= extractData;
          resp_fault <= 1'b0;
        end
      end

      // Stores report zero data on completion.
      if (state == ST_WR) begin
        resp_rdata <= 32'h0;
        resp_fault <= 1'b0;
      end
    end
  end

endmodule
